// File: rtl/apb_regfile_slave.sv
// APB4 register-file slave: NUM_WORDS x DATA_W storage with byte strobes,
// programmable wait states, PSLVERR on bad/unaligned address or read-only write,
// and all words plus per-word write pulses exported to downstream logic.
module apb_regfile_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_WORDS   = 4,
  parameter int WAIT_STATES = 0,
  parameter logic [NUM_WORDS-1:0] RO_MASK = '0
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic [DATA_W-1:0]           PWDATA,
  input  logic [DATA_W/8-1:0]         PSTRB,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [NUM_WORDS*DATA_W-1:0] reg_out,
  output logic [NUM_WORDS-1:0]        wr_pulse
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IW     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [ADDR_W-1:0] NB_A = ADDR_W'(NBYTES);
  localparam logic [ADDR_W-1:0] NW_A = ADDR_W'(NUM_WORDS);
  localparam logic [3:0]        WS_C = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                latch;

  logic [DATA_W-1:0]   mem [NUM_WORDS];

  // Transfer context captured in the first access cycle
  logic [IW-1:0]       idx_q;
  logic                wr_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NBYTES-1:0]   strb_q;

  // Live address decode (used only in IDLE)
  logic [ADDR_W-1:0]   addr_word;
  logic                misalign;
  logic                in_range;
  logic [IW-1:0]       idx_d;
  logic                err_d;

  // Context actually used when entering RESP (live in IDLE, latched otherwise)
  logic [IW-1:0]       idx_sel;
  logic                err_sel;

  // Decode the live PADDR into word index and error flag
  always_comb begin
    addr_word = PADDR / NB_A;
    misalign  = (PADDR % NB_A) != '0;
    in_range  = addr_word < NW_A;
    idx_d     = addr_word[IW-1:0];
    err_d     = misalign | ~in_range | (PWRITE & in_range & RO_MASK[idx_d]);
  end

  // Zero-wait transfers enter RESP on the same edge they latch, so bypass the latch
  always_comb begin
    idx_sel = (state == S_IDLE) ? idx_d : idx_q;
    err_sel = (state == S_IDLE) ? err_d : err_q;
  end

  // Next-state logic and wait-state counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (PSEL && PENABLE) begin
          latch     = 1'b1;
          cnt_nxt   = WS_C;
          state_nxt = (WS_C == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd1) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: state_nxt = S_DONE;
      S_DONE: begin
        // Holding PENABLE after completion must not start another transfer
        if (!PENABLE) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture address/direction/error/write payload at the start of a transfer
  always_ff @(posedge PCLK) begin
    if (latch) begin
      idx_q   <= idx_d;
      wr_q    <= PWRITE;
      err_q   <= err_d;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // State, registered response outputs, memory commit and write pulses
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      PRDATA   <= '0;
      wr_pulse <= '0;
      for (int k = 0; k < NUM_WORDS; k++) mem[k] <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      PREADY  <= (state_nxt == S_RESP);
      PSLVERR <= (state_nxt == S_RESP) && err_sel;
      if (state_nxt == S_RESP) begin
        PRDATA <= err_sel ? '0 : mem[idx_sel];
      end
      wr_pulse <= '0;
      if (state == S_RESP && wr_q && !err_q) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
        wr_pulse <= NUM_WORDS'(1) << idx_q;
      end
    end
  end

  // Flatten storage onto the exported bus
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_out
    assign reg_out[k*DATA_W +: DATA_W] = mem[k];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: two slave instances (zero-wait with a read-only word, and
// three wait states) sharing the APB bus apart from their selects.
module tb_apb_regfile_slave;

  logic         PCLK = 1'b0;
  logic         PRESET;
  logic         psel0, psel1;
  logic         PENABLE, PWRITE;
  logic [7:0]   PADDR;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;

  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [127:0] reg_out0, reg_out1;
  logic [3:0]   wr_pulse0, wr_pulse1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 PCLK = ~PCLK;

  apb_regfile_slave #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(4), .WAIT_STATES(0),
                      .RO_MASK(4'b0100)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .reg_out(reg_out0), .wr_pulse(wr_pulse0));

  apb_regfile_slave #(.ADDR_W(8), .DATA_W(32), .NUM_WORDS(4), .WAIT_STATES(3),
                      .RO_MASK(4'b0000)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .reg_out(reg_out1), .wr_pulse(wr_pulse1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full APB transfer; lat = cycles from access phase to PREADY (-1 on timeout)
  task automatic xfer(input bit d, input bit w, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output int lat, output logic [31:0] rd,
                      output logic er, output logic [3:0] wp);
    @(negedge PCLK);
    psel0 = !d; psel1 = d; PWRITE = w; PADDR = a; PWDATA = wd; PSTRB = st; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    lat = -1; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge PCLK);
      if ((d ? pready1 : pready0) === 1'b1) begin
        lat = i;
        rd  = d ? prdata1 : prdata0;
        er  = d ? pslverr1 : pslverr0;
        break;
      end
    end
    psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    wp = d ? wr_pulse1 : wr_pulse0;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  wp;
    int          rdy_cnt, wp_cnt;
    logic [3:0]  wp_or;

    PRESET = 1'b1; psel0 = 0; psel1 = 0; PENABLE = 0; PWRITE = 0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;

    // Reset
    repeat (2) @(negedge PCLK);
    chk("rst_pready", 128'(pready0), 128'd0);
    chk("rst_pslverr", 128'(pslverr0), 128'd0);
    chk("rst_prdata", 128'(prdata0), 128'd0);
    chk("rst_regout0", reg_out0, 128'd0);
    chk("rst_regout1", reg_out1, 128'd0);
    PRESET = 1'b0;

    // Full-word write and read back, zero wait states
    xfer(0, 1, 8'h04, 32'hDEADBEEF, 4'hF, lat, rd, er, wp);
    chk("wr4_lat", 128'(lat), 128'd1);
    chk("wr4_err", 128'(er), 128'd0);
    chk("wr4_pulse", 128'(wp), 128'b0010);
    chk("wr4_word1", 128'(reg_out0[63:32]), 128'hDEADBEEF);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, lat, rd, er, wp);
    chk("rd4_data", 128'(rd), 128'hDEADBEEF);
    chk("rd4_err", 128'(er), 128'd0);
    chk("rd4_pulse", 128'(wp), 128'd0);

    // Byte strobes
    xfer(0, 1, 8'h00, 32'h11223344, 4'hF, lat, rd, er, wp);
    xfer(0, 1, 8'h00, 32'hAABBCCDD, 4'h5, lat, rd, er, wp);
    chk("strb_word0", 128'(reg_out0[31:0]), 128'h11BB33DD);
    xfer(0, 0, 8'h00, 32'h0, 4'hF, lat, rd, er, wp);
    chk("strb_rd", 128'(rd), 128'h11BB33DD);
    xfer(0, 1, 8'h0C, 32'hFFFFFFFF, 4'h0, lat, rd, er, wp);
    chk("strb0_err", 128'(er), 128'd0);
    chk("strb0_pulse", 128'(wp), 128'b1000);
    chk("strb0_word3", 128'(reg_out0[127:96]), 128'd0);

    // Error responses
    xfer(0, 0, 8'h02, 32'h0, 4'hF, lat, rd, er, wp);
    chk("misalign_err", 128'(er), 128'd1);
    chk("misalign_rd", 128'(rd), 128'd0);
    chk("pslverr_idle", 128'(pslverr0), 128'd0);
    xfer(0, 1, 8'h10, 32'h55555555, 4'hF, lat, rd, er, wp);
    chk("range_err", 128'(er), 128'd1);
    chk("range_pulse", 128'(wp), 128'd0);
    xfer(0, 1, 8'h08, 32'h66666666, 4'hF, lat, rd, er, wp);
    chk("ro_err", 128'(er), 128'd1);
    chk("ro_rd", 128'(rd), 128'd0);
    chk("ro_pulse", 128'(wp), 128'd0);
    chk("err_mem", reg_out0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h11BB33DD});
    xfer(0, 0, 8'h08, 32'h0, 4'hF, lat, rd, er, wp);
    chk("ro_read_err", 128'(er), 128'd0);

    // Three wait states
    xfer(1, 1, 8'h04, 32'h12345678, 4'hF, lat, rd, er, wp);
    chk("ws3_lat", 128'(lat), 128'd4);
    chk("ws3_pulse", 128'(wp), 128'b0010);
    chk("ws3_word1", 128'(reg_out1[63:32]), 128'h12345678);
    xfer(1, 0, 8'h04, 32'h0, 4'hF, lat, rd, er, wp);
    chk("ws3_rd", 128'(rd), 128'h12345678);

    // PSEL dropped during wait states: no completion, no commit
    rdy_cnt = 0; wp_or = '0;
    @(negedge PCLK);
    psel1 = 1; PWRITE = 1; PADDR = 8'h08; PWDATA = 32'h77777777; PSTRB = 4'hF; PENABLE = 0;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK); rdy_cnt += int'(pready1);
    @(negedge PCLK); rdy_cnt += int'(pready1); psel1 = 0; PENABLE = 0;
    repeat (6) begin
      @(negedge PCLK); rdy_cnt += int'(pready1); wp_or |= wr_pulse1;
    end
    chk("abort_pready", 128'(rdy_cnt), 128'd0);
    chk("abort_pulse", 128'(wp_or), 128'd0);
    chk("abort_word2", 128'(reg_out1[95:64]), 128'd0);

    // Reset during wait states of a write
    rdy_cnt = 0; wp_or = '0;
    @(negedge PCLK);
    psel1 = 1; PWRITE = 1; PADDR = 8'h0C; PWDATA = 32'h88888888; PSTRB = 4'hF; PENABLE = 0;
    @(negedge PCLK); PENABLE = 1;
    @(negedge PCLK); PRESET = 1;
    @(negedge PCLK); PRESET = 0; psel1 = 0; PENABLE = 0;
    repeat (6) begin
      @(negedge PCLK); rdy_cnt += int'(pready1); wp_or |= wr_pulse1;
    end
    chk("rstmid_pready", 128'(rdy_cnt), 128'd0);
    chk("rstmid_pulse", 128'(wp_or), 128'd0);
    chk("rstmid_mem1", reg_out1, 128'd0);
    chk("rstmid_mem0", reg_out0, 128'd0);

    // PENABLE held after completion: exactly one PREADY and one write pulse
    rdy_cnt = 0; wp_cnt = 0;
    @(negedge PCLK);
    psel0 = 1; PWRITE = 1; PADDR = 8'h00; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF; PENABLE = 0;
    @(negedge PCLK); PENABLE = 1;
    repeat (8) begin
      @(negedge PCLK); rdy_cnt += int'(pready0); wp_cnt += int'(wr_pulse0[0]);
    end
    psel0 = 0; PENABLE = 0;
    repeat (2) begin
      @(negedge PCLK); rdy_cnt += int'(pready0); wp_cnt += int'(wr_pulse0[0]);
    end
    chk("hold_pready", 128'(rdy_cnt), 128'd1);
    chk("hold_pulse", 128'(wp_cnt), 128'd1);
    chk("hold_word0", 128'(reg_out0[31:0]), 128'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
